// File: rtl/systolic_skew_sched.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_sched
// Purpose  : Skews one tile of row-vector beats onto the array west edge.
//            SKEW_SCHED_ZERO_BUBBLE_EN forces zero data into bubble stages.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_skew_sched #(
  parameter int WIDTH = 32,
  parameter int ROWS  = 4,
  parameter int LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*WIDTH-1:0] in_data,
  input  logic                  stall,
  output logic [ROWS*WIDTH-1:0] out_data,
  output logic [ROWS-1:0]       out_valid
);

  localparam int                 c_CNT_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'((ROWS > 1) ? ROWS - 2 : 0);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FILL  = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic [c_CNT_W-1:0] r_drain_cnt;

  logic               w_adv;
  logic               w_accept;
  logic [LEN_W-1:0]   w_beat_next;

  assign w_adv       = ~stall;
  // Ready is a pure function of state and stall so upstream never sees a loop.
  assign in_ready    = (r_state == c_FILL) & ~stall;
  assign w_accept    = in_valid & in_ready;
  assign w_beat_next = r_beat_cnt + 1'b1;
  assign busy        = (r_state != c_IDLE);
  assign done        = (r_state == c_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_IDLE;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
    end else if (w_adv) begin
      case (r_state)
        c_IDLE: begin
          if (start && (len != '0)) begin
            r_len      <= len;
            r_beat_cnt <= '0;
            r_state    <= c_FILL;
          end
        end
        c_FILL: begin
          if (w_accept) begin
            r_beat_cnt <= w_beat_next;
            if (w_beat_next == r_len) begin
              r_drain_cnt <= '0;
              r_state     <= (ROWS == 1) ? c_DONE : c_DRAIN;
            end
          end
        end
        c_DRAIN: begin
          // ROWS-1 advances let the last beat reach the bottom row.
          if (r_drain_cnt == c_DRAIN_LAST) begin
            r_state <= c_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [WIDTH-1:0] w_lane;
    logic [WIDTH-1:0] r_data [0:r];
    logic             r_vld  [0:r];

`ifdef SKEW_SCHED_ZERO_BUBBLE_EN
    assign w_lane = w_accept ? in_data[r*WIDTH +: WIDTH] : '0;
`else
    assign w_lane = in_data[r*WIDTH +: WIDTH];
`endif

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int s = 0; s <= r; s++) begin
          r_data[s] <= '0;
          r_vld[s]  <= 1'b0;
        end
      end else if (w_adv) begin
        r_data[0] <= w_lane;
        r_vld[0]  <= w_accept;
        for (int s = 1; s <= r; s++) begin
          r_data[s] <= r_data[s-1];
          r_vld[s]  <= r_vld[s-1];
        end
      end
    end

    assign out_data[r*WIDTH +: WIDTH] = r_data[r];
    assign out_valid[r]               = r_vld[r];
  end

endmodule
`default_nettype wire
